// File: rtl/param_shift_reg_if.sv
// Bundles the control, data and status signals of param_shift_reg.
// The master side drives load/shift/run requests, the slave side is the register itself.
interface param_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);

  logic             ld;
  logic [WIDTH-1:0] din;
  logic             en;
  logic [1:0]       mode;
  logic             sin;
  logic             start;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] q;
  logic             sd;
  logic             busy;
  logic             done;

  modport master (
    output ld, din, en, mode, sin, start, cnt,
    input  q, sd, busy, done
  );

  modport slave (
    input  ld, din, en, mode, sin, start, cnt,
    output q, sd, busy, done
  );

endinterface

// File: rtl/param_shift_reg.sv
// Parametrised shift register for the Booth multiplier datapath and later serial units.
// Offers parallel load, single-step shift and an autonomous N-step run with a
// start/busy/done handshake. Shift modes: 00 arithmetic right, 01 logical right
// with serial fill, 10 left with serial fill, 11 rotate right.
// Optional feature macro: PSR_ROTATE_EN. When it is undefined, mode 11 behaves
// exactly like mode 00 (arithmetic right), for both the shift and sd.
// WIDTH must be at least 2 and 2**CNT_W must exceed WIDTH.
module param_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic              clk,
  input logic              reset,
  param_shift_reg_if.slave bus
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CNT_W-1:0] remaining;
  logic [1:0]       latched_mode;
  logic             done_r;
  logic [1:0]       eff_mode;

  // One shift step of value v in mode m, with s as the serial fill bit.
  function automatic logic [WIDTH-1:0] shift_once(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] v,
    input logic             s
  );
    logic [WIDTH-1:0] r;
    r = v;
    case (m)
      2'b01:   r = {s, v[WIDTH-1:1]};
      2'b10:   r = {v[WIDTH-2:0], s};
`ifdef PSR_ROTATE_EN
      2'b11:   r = {v[0], v[WIDTH-1:1]};
`endif
      default: r = {v[WIDTH-1], v[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  // A run owns the mode it latched at start; otherwise the live mode is in effect.
  always_comb begin
    eff_mode = bus.mode;
    if (state == RUN) begin
      eff_mode = latched_mode;
    end
  end

  // Main register and run controller: reset > ld > active run > start > en > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      shreg        <= '0;
      remaining    <= '0;
      latched_mode <= 2'b00;
      done_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bus.ld) begin
        shreg     <= bus.din;
        state     <= IDLE;
        remaining <= '0;
      end else if (state == RUN) begin
        shreg     <= shift_once(latched_mode, shreg, bus.sin);
        remaining <= remaining - CNT_W'(1);
        if (remaining == CNT_W'(1)) begin
          state  <= IDLE;
          done_r <= 1'b1;
        end
      end else if (bus.start) begin
        latched_mode <= bus.mode;
        if (bus.cnt == '0) begin
          done_r <= 1'b1;
        end else begin
          state     <= RUN;
          remaining <= bus.cnt;
        end
      end else if (bus.en) begin
        shreg <= shift_once(bus.mode, shreg, bus.sin);
      end
    end
  end

  assign bus.q    = shreg;
  assign bus.busy = (state == RUN);
  assign bus.done = done_r;
  assign bus.sd   = (eff_mode == 2'b10) ? shreg[WIDTH-1] : shreg[0];

endmodule

// File: tb/tb_param_shift_reg.sv
// Self-checking bench for param_shift_reg (WIDTH=8, CNT_W=4).
// Expected register values are pushed to a scoreboard queue when stimulus is
// driven and popped when the design presents the result.
module tb_param_shift_reg;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [WIDTH-1:0] exp_q[$];

  param_shift_reg_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  param_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference shift, written independently from the design.
  function automatic logic [WIDTH-1:0] model_shift(
    input logic [1:0]       m,
    input logic [WIDTH-1:0] v,
    input logic             s
  );
    logic [WIDTH-1:0] r;
    case (m)
      2'b01: r = (v >> 1) | ({{(WIDTH-1){1'b0}}, s} << (WIDTH-1));
      2'b10: r = (v << 1) | {{(WIDTH-1){1'b0}}, s};
`ifdef PSR_ROTATE_EN
      2'b11: r = (v >> 1) | (v << (WIDTH-1));
`else
      2'b11: r = WIDTH'($signed(v) >>> 1);
`endif
      default: r = WIDTH'($signed(v) >>> 1);
    endcase
    return r;
  endfunction

  // Advance one clock edge; outputs are then sampled 1 unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] value);
    bus.ld  = 1'b1;
    bus.din = value;
    tick();
    bus.ld  = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sd !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: q=%h busy=%b done=%b sd=%b, required q=00 busy=0 done=0 sd=0",
               bus.q, bus.busy, bus.done, bus.sd);
    end
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    int done_seen;
    load(8'hAA);
    bus.mode  = 2'b00;
    bus.cnt   = 4'd5;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.q !== 8'h00 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_run: q=%h busy=%b done=%b, required q=00 busy=0 done=0",
               bus.q, bus.busy, bus.done);
    end
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen !== 0) begin
      errors++;
      $display("[TB] FAIL reset_mid_run_quiet: busy/done seen %0d times, required 0", done_seen);
    end
  endtask

  task automatic test_single_shift;
    logic [WIDTH-1:0] want;
    load(8'hB4);
    bus.mode = 2'b00;
    bus.en   = 1'b1;
    #1;
    checks++;
    if (bus.sd !== 1'b0) begin
      errors++;
      $display("[TB] FAIL asr_sd_before: sd=%b, required 0", bus.sd);
    end
    exp_q.push_back(8'hDA);
    tick();
    bus.en = 1'b0;
    want = exp_q.pop_front();
    checks++;
    if (bus.q !== want) begin
      errors++;
      $display("[TB] FAIL asr_single: q=%h, required %h", bus.q, want);
    end
  endtask

  task automatic test_lsr_run;
    int busy_cycles;
    int done_count;
    logic [WIDTH-1:0] want;
    load(8'h81);
    bus.mode  = 2'b01;
    bus.sin   = 1'b0;
    bus.cnt   = 4'd3;
    bus.start = 1'b1;
    exp_q.push_back(8'h10);
    tick();
    busy_cycles = 0;
    done_count  = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.busy === 1'b1) busy_cycles++;
      if (bus.done === 1'b1) begin
        done_count++;
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          checks++;
          if (bus.q !== want) begin
            errors++;
            $display("[TB] FAIL lsr_run_q: q=%h, required %h", bus.q, want);
          end
        end
      end
      bus.en    = (bus.busy === 1'b1) ? ~bus.en : 1'b0;
      bus.start = (bus.busy === 1'b1) ? i[0] : 1'b0;
      bus.mode  = (bus.busy === 1'b1) ? 2'b10 : 2'b01;
      bus.cnt   = CNT_W'($urandom_range(0, 15));
      tick();
    end
    bus.en    = 1'b0;
    bus.start = 1'b0;
    exp_q.delete();
    checks++;
    if (busy_cycles !== 3) begin
      errors++;
      $display("[TB] FAIL lsr_run_busy: busy cycles=%0d, required 3", busy_cycles);
    end
    checks++;
    if (done_count !== 1) begin
      errors++;
      $display("[TB] FAIL lsr_run_done: done pulses=%0d, required 1", done_count);
    end
  endtask

  task automatic test_shl_run;
    logic [WIDTH-1:0] mq;
    logic [WIDTH-1:0] want;
    int done_count;
    load(8'h0F);
    mq        = 8'h0F;
    bus.mode  = 2'b10;
    bus.sin   = 1'b1;
    bus.cnt   = 4'd4;
    bus.start = 1'b1;
    exp_q.push_back(8'hFF);
    tick();
    bus.start  = 1'b0;
    done_count = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.busy === 1'b1) begin
        checks++;
        if (bus.sd !== mq[WIDTH-1]) begin
          errors++;
          $display("[TB] FAIL shl_run_sd: step %0d sd=%b, required %b", i, bus.sd, mq[WIDTH-1]);
        end
        mq = model_shift(2'b10, mq, 1'b1);
      end
      if (bus.done === 1'b1 && exp_q.size() != 0) begin
        done_count++;
        want = exp_q.pop_front();
        checks++;
        if (bus.q !== want || bus.sd !== 1'b1) begin
          errors++;
          $display("[TB] FAIL shl_run_q: q=%h sd=%b, required q=%h sd=1", bus.q, bus.sd, want);
        end
      end
      tick();
    end
    exp_q.delete();
    checks++;
    if (done_count !== 1) begin
      errors++;
      $display("[TB] FAIL shl_run_done: done pulses=%0d, required 1", done_count);
    end
  endtask

  task automatic test_zero_and_abort;
    logic [WIDTH-1:0] want;
    bus.mode  = 2'b00;
    bus.cnt   = 4'd0;
    bus.start = 1'b1;
    exp_q.push_back(8'hFF);
    tick();
    bus.start = 1'b0;
    want = exp_q.pop_front();
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.q !== want) begin
      errors++;
      $display("[TB] FAIL zero_count: done=%b busy=%b q=%h, required done=1 busy=0 q=%h",
               bus.done, bus.busy, bus.q, want);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_count_pulse: done=%b, required 0", bus.done);
    end
    load(8'h80);
    bus.cnt   = 4'd6;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.q !== 8'hE0 || bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_progress: q=%h busy=%b, required q=e0 busy=1", bus.q, bus.busy);
    end
    exp_q.push_back(8'h3C);
    load(8'h3C);
    want = exp_q.pop_front();
    checks++;
    if (bus.q !== want || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_ld: q=%h busy=%b done=%b, required q=%h busy=0 done=0",
               bus.q, bus.busy, bus.done, want);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.q !== 8'h3C) begin
        errors++;
        $display("[TB] FAIL abort_quiet: q=%h busy=%b done=%b, required q=3c busy=0 done=0",
                 bus.q, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_rotate;
    logic [WIDTH-1:0] want;
    load(8'h01);
    bus.mode  = 2'b11;
    bus.cnt   = 4'd1;
    bus.start = 1'b1;
`ifdef PSR_ROTATE_EN
    exp_q.push_back(8'h80);
`else
    exp_q.push_back(8'h00);
`endif
    tick();
    bus.start = 1'b0;
    tick();
    want = exp_q.pop_front();
    checks++;
    if (bus.done !== 1'b1 || bus.q !== want) begin
      errors++;
      $display("[TB] FAIL mode11_run: done=%b q=%h, required done=1 q=%h", bus.done, bus.q, want);
    end
  endtask

  task automatic test_long_run;
    logic [WIDTH-1:0] want;
    int busy_cycles;
    int seen;
    load(8'h80);
    bus.mode  = 2'b00;
    bus.cnt   = 4'd12;
    bus.start = 1'b1;
    exp_q.push_back(8'hFF);
    tick();
    bus.start   = 1'b0;
    busy_cycles = 0;
    seen        = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      if (bus.busy === 1'b1) busy_cycles++;
      if (bus.done === 1'b1) begin
        seen = 1;
        want = exp_q.pop_front();
        checks++;
        if (bus.q !== want) begin
          errors++;
          $display("[TB] FAIL long_asr_q: q=%h, required %h", bus.q, want);
        end
      end else begin
        tick();
      end
    end
    exp_q.delete();
    checks++;
    if (seen !== 1 || busy_cycles !== 12) begin
      errors++;
      $display("[TB] FAIL long_asr_timing: done seen=%0d busy cycles=%0d, required 1 and 12",
               seen, busy_cycles);
    end
  endtask

  task automatic test_random_shifts;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] want;
    cur = WIDTH'($urandom);
    load(cur);
    for (int i = 0; i < 24; i++) begin
      bus.mode = 2'($urandom_range(0, 3));
      bus.sin  = 1'($urandom_range(0, 1));
      bus.en   = 1'b1;
      cur = model_shift(bus.mode, cur, bus.sin);
      exp_q.push_back(cur);
      tick();
      bus.en = 1'b0;
      want = exp_q.pop_front();
      checks++;
      if (bus.q !== want) begin
        errors++;
        $display("[TB] FAIL random_shift: step %0d q=%h, required %h", i, bus.q, want);
      end
    end
  endtask

  // Scenario sequence.
  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.ld    = 1'b0;
    bus.din   = '0;
    bus.en    = 1'b0;
    bus.mode  = 2'b00;
    bus.sin   = 1'b0;
    bus.start = 1'b0;
    bus.cnt   = '0;
    test_reset();
    test_reset_mid_run();
    test_single_shift();
    test_lsr_run();
    test_shl_run();
    test_zero_and_abort();
    test_rotate();
    test_long_run();
    test_random_shifts();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
